// File: rtl/ldpc_dvb_dec_iter_ctrl.sv
// DVB LDPC decoder iteration controller: launches iterations, restarts the
// decfail counter, decides stop. Early stop: LDPC_DVB_DEC_ITER_CTRL_EARLY_STOP_EN.
module ldpc_dvb_dec_iter_ctrl #(
  parameter int pITER_W   = 8,
  parameter int pMIN_ITER = 1,
  parameter int pCNT_DLY  = 8
) (
  input  logic               iclk,
  input  logic               ireset,
  input  logic               iclkena,
  input  logic               istart,
  input  logic [pITER_W-1:0] iNiter,
  output logic               ordy,
  output logic               odec_start,
  output logic               odec_load_iter,
  input  logic               idec_done,
  output logic               ocnt_start,
  output logic               ocnt_load_iter,
  input  logic               icnt_decfail,
  output logic               odone,
  output logic               odecfail,
  output logic [pITER_W-1:0] oused_iter
);

  localparam int DLY_W = (pCNT_DLY > 1) ? $clog2(pCNT_DLY) : 1;

  localparam logic [DLY_W-1:0] DLY_LOAD = DLY_W'(pCNT_DLY - 1);
  localparam logic [pITER_W:0] MIN_ITER = (pITER_W + 1)'(pMIN_ITER);

  localparam logic [2:0] IDLE  = 3'd0;
  localparam logic [2:0] START = 3'd1;
  localparam logic [2:0] RUN   = 3'd2;
  localparam logic [2:0] CHECK = 3'd3;
  localparam logic [2:0] DONE  = 3'd4;

  logic [2:0]         state;
  logic [pITER_W-1:0] niter;
  logic [pITER_W-1:0] k;
  logic [DLY_W-1:0]   dly;
  logic [pITER_W:0]   k1;
  logic               first;
  logic               last;
  logic               stop_early;

  // k1 carries one extra bit so the limit compare never sees a wrap
  assign k1    = {1'b0, k} + (pITER_W + 1)'(1);
  assign last  = (k1 == {1'b0, niter});
  assign first = (k == '0);

`ifdef LDPC_DVB_DEC_ITER_CTRL_EARLY_STOP_EN
  assign stop_early = !icnt_decfail && (k1 >= MIN_ITER);
`else
  assign stop_early = 1'b0;
`endif

  // Pulses decode straight from state, so a frozen clock holds them
  assign ordy           = (state == IDLE);
  assign odec_start     = (state == START);
  assign ocnt_start     = (state == START);
  assign ocnt_load_iter = (state == START) && first;
  assign odone          = (state == DONE);
  assign odec_load_iter = first &&
    ((state == START) || (state == RUN) || (state == CHECK));

  always_ff @(posedge iclk or posedge ireset) begin
    if (ireset) begin
      state      <= IDLE;
      niter      <= '0;
      k          <= '0;
      dly        <= '0;
      odecfail   <= 1'b0;
      oused_iter <= '0;
    end else if (iclkena) begin
      unique case (state)
        IDLE: begin
          if (istart) begin
            niter <= (iNiter == '0) ? pITER_W'(1) : iNiter;
            k     <= '0;
            state <= START;
          end
        end
        START: state <= RUN;
        RUN: begin
          if (idec_done) begin
            dly   <= DLY_LOAD;
            state <= CHECK;
          end
        end
        CHECK: begin
          if (dly != '0) begin
            dly <= dly - 1'b1;
          end else if (stop_early) begin
            odecfail   <= 1'b0;
            oused_iter <= k1[pITER_W-1:0];
            state      <= DONE;
          end else if (last) begin
            odecfail   <= icnt_decfail;
            oused_iter <= k1[pITER_W-1:0];
            state      <= DONE;
          end else begin
            k     <= k1[pITER_W-1:0];
            state <= START;
          end
        end
        DONE:    state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end

endmodule
